// File: rtl/reset_requester_pkg.sv
// reset_requester_pkg: shared constants for the reset request source.
// Holds the FSM state encoding, the cause flag bit positions and a small
// saturating-increment helper used by the pulse/holdoff counter.
package reset_requester_pkg;

    // Two-bit FSM encoding.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ASSERT  = 2'd1;
    localparam logic [1:0] HOLDOFF = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_ASSERT  = ASSERT,
        ST_HOLDOFF = HOLDOFF
    } state_e;

    // Bit positions inside rst_cause.
    localparam int CAUSE_BTN = 0;
    localparam int CAUSE_SW  = 1;
    localparam int CAUSE_WDT = 2;
    localparam int CAUSE_W   = 3;

    // Width of the shared pulse/holdoff counter.
    localparam int PULSE_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PULSE_CNT_W-1:0] sat_inc8(input logic [PULSE_CNT_W-1:0] v);
        logic [PULSE_CNT_W-1:0] r;
        if (v == {PULSE_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reset_requester_btn_debounce.sv
// btn_debounce: two-flop synchronizer followed by a stability counter for an
// active-low front-panel button. The debounced level only moves after the
// synchronized input has disagreed with it for 2^DEBOUNCE_BITS consecutive
// cycles; any return to the current level restarts the count. press_o is a
// one-cycle strobe on the released -> pressed transition of the debounced level.
// Generic enough to be reused for other front-panel buttons.
module btn_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = {DEBOUNCE_BITS{1'b1}};

    logic                     sync1_q;
    logic                     sync2_q;
    logic                     level_q;
    logic                     level_d;
    logic                     press_q;
    logic                     press_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q;
    logic [DEBOUNCE_BITS-1:0] cnt_d;

    // Bring the asynchronous button into clk; reset to "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; flip the level on the last one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                cnt_d   = '0;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/reset_requester.sv
// reset_requester: source side of the system reset request line.
// Collects a debounced front-panel button, a software strobe and (optionally)
// a watchdog timeout, and turns the first one seen while idle into a clean
// PULSE_CYCLES-long rstreq pulse, followed by a holdoff that waits for the
// button to be released. The cause(s) that fired are latched in rst_cause.
// Build option: define RESET_REQUESTER_WATCHDOG_EN to include the watchdog;
// without it the watchdog inputs are ignored and rst_cause[2] stays 0.
// The reset input must come from PLL-lock logic, never from the reset that
// rstreq itself produces, so a request cannot cut its own pulse short.
module reset_requester
    import reset_requester_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16,
    parameter int PULSE_CYCLES  = 32,
    parameter int WDT_BITS      = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       sw_rstreq,
    input  logic       wdt_enable,
    input  logic       wdt_kick,
    input  logic       cause_clr,
    output logic       rstreq,
    output logic       busy,
    output logic [2:0] rst_cause
);

    // Last count value of the pulse; also the minimum holdoff length.
    localparam logic [PULSE_CNT_W-1:0] PULSE_LAST = PULSE_CNT_W'(PULSE_CYCLES - 1);

    state_e                 state_q;
    logic                   rstreq_q;
    logic                   busy_q;
    logic [CAUSE_W-1:0]     cause_q;
    logic [PULSE_CNT_W-1:0] pulse_cnt_q;

    logic                   btn_level;
    logic                   btn_press;
    logic                   wdt_timeout;
    logic                   trigger;
    logic                   enter_assert;
    logic [CAUSE_W-1:0]     trig_cause;

    btn_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_btn_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_n_i(btn_n),
        .level_o(btn_level),
        .press_o(btn_press)
    );

`ifdef RESET_REQUESTER_WATCHDOG_EN
    localparam logic [WDT_BITS-1:0] WDT_MAX = {WDT_BITS{1'b1}};

    logic [WDT_BITS-1:0] wdt_cnt_q;

    // The timeout is a single cycle: the next increment wraps the counter.
    assign wdt_timeout = (wdt_cnt_q == WDT_MAX);

    // Watchdog counter: runs while enabled, cleared by a kick, by disabling
    // and when a request is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt_q <= '0;
        end else if (!wdt_enable || wdt_kick || enter_assert) begin
            wdt_cnt_q <= '0;
        end else begin
            wdt_cnt_q <= wdt_cnt_q + 1'b1;
        end
    end
`else
    // Watchdog inputs are consumed here only to keep them visibly unused.
    logic [WDT_BITS-1:0] unused_wdt_inputs;
    assign unused_wdt_inputs = {WDT_BITS{wdt_enable ^ wdt_kick}};
    assign wdt_timeout       = 1'b0;
`endif

    // Cause vector for a trigger in this cycle; all simultaneous causes count.
    always_comb begin
        trig_cause            = '0;
        trig_cause[CAUSE_BTN] = btn_press;
        trig_cause[CAUSE_SW]  = sw_rstreq;
        trig_cause[CAUSE_WDT] = wdt_timeout;
    end

    assign trigger      = |trig_cause;
    assign enter_assert = (state_q == ST_IDLE) && trigger;

    // Request FSM with registered rstreq, busy and cause flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rstreq_q    <= 1'b0;
            busy_q      <= 1'b0;
            cause_q     <= '0;
            pulse_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        // A new latch overrides a coincident clear.
                        state_q     <= ST_ASSERT;
                        rstreq_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        pulse_cnt_q <= '0;
                        cause_q     <= trig_cause;
                    end else if (cause_clr) begin
                        cause_q <= '0;
                    end
                end
                ST_ASSERT: begin
                    // Triggers are dropped here; only a clear touches the flags.
                    if (cause_clr) begin
                        cause_q <= '0;
                    end
                    if (pulse_cnt_q == PULSE_LAST) begin
                        state_q     <= ST_HOLDOFF;
                        rstreq_q    <= 1'b0;
                        pulse_cnt_q <= '0;
                    end else begin
                        pulse_cnt_q <= sat_inc8(pulse_cnt_q);
                    end
                end
                ST_HOLDOFF: begin
                    if (cause_clr) begin
                        cause_q <= '0;
                    end
                    // Leave only once the minimum time is up and the button is
                    // released, so a held button cannot retrigger.
                    if ((pulse_cnt_q >= PULSE_LAST) && btn_level) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        pulse_cnt_q <= sat_inc8(pulse_cnt_q);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rstreq_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    pulse_cnt_q <= '0;
                end
            endcase
        end
    end

    assign rstreq    = rstreq_q;
    assign busy      = busy_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_requester.sv
// tb_reset_requester: scoreboard bench for reset_requester.
// A behavioural model (stable-run counting, pulse/holdoff countdowns) predicts
// every change of rstreq, busy and rst_cause and queues it with its cycle; a
// separate monitor pops and compares whenever the DUT output changes.
module tb_reset_requester;

    localparam int DB     = 4;
    localparam int PULSE  = 8;
    localparam int WB     = 6;
    localparam int DB_LEN = 1 << DB;
    localparam int WLIM   = (1 << WB) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       sw_rstreq = 1'b0;
    logic       wdt_enable = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       cause_clr = 1'b0;
    logic       rstreq;
    logic       busy;
    logic [2:0] rst_cause;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } ev_t;

    ev_t q_req[$];
    ev_t q_busy[$];
    ev_t q_cause[$];

    // model state
    bit         m_s1, m_s2, m_deb, m_press, m_req, m_busy;
    int         m_run, m_wcnt, m_mode, m_left, m_hold;
    logic [2:0] m_cause;

    reset_requester #(
        .DEBOUNCE_BITS(DB),
        .PULSE_CYCLES (PULSE),
        .WDT_BITS     (WB)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .btn_n     (btn_n),
        .sw_rstreq (sw_rstreq),
        .wdt_enable(wdt_enable),
        .wdt_kick  (wdt_kick),
        .cause_clr (cause_clr),
        .rstreq    (rstreq),
        .busy      (busy),
        .rst_cause (rst_cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got hang, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end else begin
            $display("[TB] %s = %0d", name, got);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1; m_s2 = 1; m_deb = 1; m_press = 0; m_req = 0; m_busy = 0;
        m_run = 0; m_wcnt = 0; m_mode = 0; m_left = 0; m_hold = 0;
        m_cause = 3'b000;
    endtask

    // Predict the effect of the next clock edge given the inputs now applied.
    task automatic model_step();
        int         t;
        bit         to, enter, new_req, new_busy;
        logic [2:0] nc;
        t = cyc + 1;
`ifdef RESET_REQUESTER_WATCHDOG_EN
        to = (m_wcnt == WLIM);
`else
        to = 1'b0;
`endif
        enter = 0;
        nc = m_cause;
        if (m_mode == 0) begin
            if (m_press || sw_rstreq || to) begin
                nc = {to, sw_rstreq, m_press};
                m_mode = 1;
                m_left = PULSE;
                enter = 1;
            end else if (cause_clr) begin
                nc = 3'b000;
            end
        end else begin
            if (cause_clr) nc = 3'b000;
            if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2;
                    m_hold = 0;
                end
            end else begin
                m_hold++;
                if (m_hold >= PULSE && m_deb) m_mode = 0;
            end
        end
        new_req  = (m_mode == 1);
        new_busy = (m_mode != 0);
        if (new_req != m_req)   q_req.push_back('{t, {2'b00, new_req}});
        if (new_busy != m_busy) q_busy.push_back('{t, {2'b00, new_busy}});
        if (nc !== m_cause)     q_cause.push_back('{t, nc});
        m_req = new_req;
        m_busy = new_busy;
        m_cause = nc;
        // button: level moves after DB_LEN consecutive disagreeing cycles
        m_press = 0;
        if (m_s2 != m_deb) begin
            m_run++;
            if (m_run == DB_LEN) begin
                m_deb = m_s2;
                m_run = 0;
                m_press = !m_deb;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = btn_n;
        // watchdog: cycles since last clear
        if (!wdt_enable || wdt_kick || enter) m_wcnt = 0;
        else m_wcnt = (m_wcnt + 1) % (WLIM + 1);
    endtask

    task automatic step(input bit s, input bit c, input bit k);
        sw_rstreq = s;
        cause_clr = c;
        wdt_kick = k;
        model_step();
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    task automatic expect_change(input int which, input string name, input logic [2:0] got);
        ev_t e;
        bit  have;
        have = 0;
        e = '{0, 3'b000};
        case (which)
            0: if (q_req.size() > 0) begin e = q_req.pop_front(); have = 1; end
            1: if (q_busy.size() > 0) begin e = q_busy.pop_front(); have = 1; end
            default: if (q_cause.size() > 0) begin e = q_cause.pop_front(); have = 1; end
        endcase
        tests++;
        if (!have) begin
            fails++;
            $display("FAIL %s unexpected change at cycle %0d: got %0d, required no change", name, cyc, got);
        end else if (e.cyc != cyc || e.val !== got) begin
            fails++;
            $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d", name, got, cyc, e.val, e.cyc);
        end else begin
            $display("[TB] %s -> %0d at cycle %0d", name, got, cyc);
        end
    endtask

    task automatic drain_missing();
        ev_t e;
        while (q_req.size() > 0 && q_req[0].cyc < cyc) begin
            e = q_req.pop_front(); tests++; fails++;
            $display("FAIL rstreq missing change: got none, required %0d at cycle %0d", e.val, e.cyc);
        end
        while (q_busy.size() > 0 && q_busy[0].cyc < cyc) begin
            e = q_busy.pop_front(); tests++; fails++;
            $display("FAIL busy missing change: got none, required %0d at cycle %0d", e.val, e.cyc);
        end
        while (q_cause.size() > 0 && q_cause[0].cyc < cyc) begin
            e = q_cause.pop_front(); tests++; fails++;
            $display("FAIL rst_cause missing change: got none, required %0d at cycle %0d", e.val, e.cyc);
        end
    endtask

    initial begin
        logic       p_req, p_busy;
        logic [2:0] p_cause;
        p_req = 0; p_busy = 0; p_cause = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                p_req = rstreq; p_busy = busy; p_cause = rst_cause;
            end else begin
                drain_missing();
                if (rstreq !== p_req) begin
                    expect_change(0, "rstreq", {2'b00, rstreq});
                    p_req = rstreq;
                end
                if (busy !== p_busy) begin
                    expect_change(1, "busy", {2'b00, busy});
                    p_busy = busy;
                end
                if (rst_cause !== p_cause) begin
                    expect_change(2, "rst_cause", rst_cause);
                    p_cause = rst_cause;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rstreq", {2'b00, rstreq}, 3'b000);
        chk("reset_busy", {2'b00, busy}, 3'b000);
        chk("reset_cause", rst_cause, 3'b000);
        rst = 1'b0;

        // software request
        repeat (2) step(0, 0, 0);
        step(1, 0, 0);
        chk("sw_rstreq_high", {2'b00, rstreq}, 3'b001);
        chk("sw_cause", rst_cause, 3'b010);
        repeat (25) step(0, 0, 0);
        chk("sw_busy_done", {2'b00, busy}, 3'b000);
        step(0, 1, 0);
        chk("clr_cause", rst_cause, 3'b000);

        // bouncy button, then stable press and release
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_n = ~btn_n;
            step(0, 0, 0);
        end
        btn_n = 1'b0;
        repeat (30) step(0, 0, 0);
        chk("bounce_cause", rst_cause, 3'b001);
        btn_n = 1'b1;
        repeat (40) step(0, 0, 0);
        step(0, 1, 0);

        // held button: one pulse only
        btn_n = 1'b0;
        repeat (200) step(0, 0, 0);
        chk("held_busy", {2'b00, busy}, 3'b001);
        btn_n = 1'b1;
        repeat (40) step(0, 0, 0);
        chk("held_idle", {2'b00, busy}, 3'b000);

        // software strobe coincident with the press event
        btn_n = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_press) begin
                found = 1;
                step(1, 0, 0);
            end else begin
                step(0, 0, 0);
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL sim_press: got no press event in 60 cycles, required one");
        end
        chk("sim_cause", rst_cause, 3'b011);
        repeat (2) step(0, 0, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        chk("sim_cause_kept", rst_cause, 3'b011);
        step(0, 1, 0);
        chk("sim_clr", rst_cause, 3'b000);
        btn_n = 1'b1;
        repeat (50) step(0, 0, 0);

        // watchdog: no kicks, then regular kicks
        wdt_enable = 1'b1;
        repeat (100) step(0, 0, 0);
`ifdef RESET_REQUESTER_WATCHDOG_EN
        chk("wdt_cause", rst_cause, 3'b100);
`else
        chk("wdt_cause_off", rst_cause, 3'b000);
`endif
        step(0, 1, 0);
        for (int i = 0; i < 200; i++) step(0, 0, (i % 40) == 39);
        chk("wdt_kicked_cause", rst_cause, 3'b000);
        wdt_enable = 1'b0;
        repeat (5) step(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 29) == 0) btn_n = ~btn_n;
            if ($urandom_range(0, 199) == 0) wdt_enable = ~wdt_enable;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0);
        end
        wdt_enable = 1'b0;
        btn_n = 1'b1;
        repeat (60) step(0, 0, 0);

        // async reset during the pulse
        step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        chk("pre_reset_rstreq", {2'b00, rstreq}, 3'b001);
        rst = 1'b1;
        #1;
        chk("async_rstreq", {2'b00, rstreq}, 3'b000);
        chk("async_busy", {2'b00, busy}, 3'b000);
        chk("async_cause", rst_cause, 3'b000);
        q_req.delete();
        q_busy.delete();
        q_cause.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) step(0, 0, 0);
        chk("post_reset_busy", {2'b00, busy}, 3'b000);

        @(posedge clk);
        #2;
        tests++;
        if (q_req.size() + q_busy.size() + q_cause.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d pending expected changes, required 0", q_req.size() + q_busy.size() + q_cause.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
